slc3_control_fsm: RTL and testbench
===================================

// Module: slc3_control_fsm
// PURPOSE
//  Moore control FSM (ISDU) for the SLC-3 datapath; sits directly upstream of the register file.
//  Sequences fetch/decode/execute; drives DR/SR1/SR2 mux selects, LD_REG, bus gates, memory strobes.
//  Supports ADD, AND, NOT, BR, JMP, JSR, LDR, STR, PAUSE. Other opcodes decode as NOP (back to fetch).
// PARAMETERS
//  MEM_WAIT  default 2  SRAM access cycles per read/write state (>=1)
// PORTS
//  Clk       in   1  system clock, all state changes on rising edge
//  Reset     in   1  reset, asynchronous, active-high
//  Run       in   1  start execution from Halted (level)
//  Continue  in   1  resume from PAUSE (level, full high-then-low handshake)
//  Opcode    in   4  IR[15:12]
//  IR_5      in   1  IR[5], immediate select for ADD/AND
//  IR_11     in   1  IR[11], JSR vs JSRR
//  BEN       in   1  branch enable from datapath (valid in decode+1)
//  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out 1 each  register loads
//  GatePC, GateMDR, GateALU, GateMARMUX  out 1 each  bus drivers, at most one high
//  PCMUX     out  2  00 PC+1, 01 bus, 10 address adder
//  DRMUX     out  1  0 IR[11:9], 1 R7
//  SR1MUX    out  1  0 IR[11:9], 1 IR[8:6]
//  SR2MUX    out  1  0 SR2 reg, 1 sext(imm5)
//  ADDR1MUX  out  1  0 PC, 1 SR1
//  ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
//  ALUK      out  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A
//  Mem_OE_n, Mem_WE_n  out 1 each  active-low SRAM strobes
// BEHAVIOUR
//  - State register only; all outputs decoded purely from state (glitch-free). Register file
//    loads on LD_REG edge, so LD_REG is high for exactly one cycle per write, never otherwise.
//  - Reset (any time, incl. mid-instruction or mid-memory access): state=HALTED immediately;
//    all LD_*/Gate* = 0, all mux selects = 0, Mem_OE_n = Mem_WE_n = 1.
//  - HALTED -> S18 when Run=1, else stay.
//  - Fetch: S18 MAR<-PC, PC<-PC+1 (GatePC, LD_MAR, LD_PC, PCMUX=00) -> S33[0..MEM_WAIT-1]
//    (Mem_OE_n=0; LD_MDR=1 in last wait cycle only) -> S35 IR<-MDR (GateMDR, LD_IR) -> S32.
//  - S32 decode: LD_BEN=1; next state by Opcode:
//    0001 ADD->S01, 0101 AND->S05, 1001 NOT->S09, 0000 BR->S00, 1100 JMP->S12, 0100 JSR->S04,
//    0110 LDR->S06, 0111 STR->S07, 1101 PAUSE->P1, else ->S18.
//  - S01/S05: SR1MUX=1, SR2MUX=IR_5, ALUK=00/01, GateALU, LD_REG, LD_CC, DRMUX=0 -> S18.
//  - S09: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC -> S18.
//  - S00: BEN=1 -> S22 else S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
//  - S12: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC -> S18.
//  - S04: R7<-PC (GatePC, DRMUX=1, LD_REG) -> S21. S21: IR_11=1: ADDR2MUX=11, ADDR1MUX=0;
//    IR_11=0: ADDR1MUX=1 (SR1MUX=1), ADDR2MUX=00; PCMUX=10, LD_PC -> S18.
//  - S06: MAR<-SR1+off6 (SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR) -> S25[wait,
//    Mem_OE_n=0, LD_MDR last cycle] -> S27 DR<-MDR (GateMDR, LD_REG, LD_CC) -> S18.
//  - S07: same MAR calc -> S23 MDR<-SR (SR1MUX=0, ALUK=11, GateALU, LD_MDR) ->
//    S16[MEM_WAIT cycles, Mem_WE_n=0] -> S18.
//  - PAUSE: P1 LD_LED=1 for one cycle, then holds until Continue=1 -> P2 holds until
//    Continue=0 -> S18. Run ignored outside HALTED.
//  - Wait counters reset to 0 on state entry; no wrap beyond MEM_WAIT-1.
// TESTING
//  - Reset mid-S33 -> next cycle HALTED, Mem_OE_n=1, all loads 0; Run=1 -> S18 following edge.
//  - ADD opcode 0001, IR_5=1, MEM_WAIT=2 -> S18,S33,S33,S35,S32,S01: LD_REG high 1 cycle, SR2MUX=1.
//  - BR with BEN=0 -> S00 then S18, LD_PC never high in S00; BEN=1 -> S22, PCMUX=10, LD_PC=1.
//  - JSR IR_11=1 -> S04 DRMUX=1 LD_REG=1, S21 ADDR2MUX=11 PCMUX=10; total 1+2+1+1+2 cycles after S18.
//  - STR -> Mem_WE_n=0 exactly MEM_WAIT cycles, Mem_OE_n stays 1, LD_REG never asserted.
//  - PAUSE: hold Continue=0 10 cycles -> stays P1; Continue 1 then 0 -> P2 then S18; LD_LED 1 pulse.

Source files
------------

// File: rtl/slc3_control_fsm.sv
// ============================================================================
// Module  : slc3_control_fsm
// Brief   : Moore instruction-sequencing control unit for the SLC-3 datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module slc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n
);

  localparam int              CW   = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(MEM_WAIT - 1);

  localparam logic [4:0] HALTED = 5'd0;
  localparam logic [4:0] S18    = 5'd1;
  localparam logic [4:0] S33    = 5'd2;
  localparam logic [4:0] S35    = 5'd3;
  localparam logic [4:0] S32    = 5'd4;
  localparam logic [4:0] S01    = 5'd5;
  localparam logic [4:0] S05    = 5'd6;
  localparam logic [4:0] S09    = 5'd7;
  localparam logic [4:0] S00    = 5'd8;
  localparam logic [4:0] S22    = 5'd9;
  localparam logic [4:0] S12    = 5'd10;
  localparam logic [4:0] S04    = 5'd11;
  localparam logic [4:0] S21    = 5'd12;
  localparam logic [4:0] S06    = 5'd13;
  localparam logic [4:0] S25    = 5'd14;
  localparam logic [4:0] S27    = 5'd15;
  localparam logic [4:0] S07    = 5'd16;
  localparam logic [4:0] S23    = 5'd17;
  localparam logic [4:0] S16    = 5'd18;
  localparam logic [4:0] P1     = 5'd19;
  localparam logic [4:0] P2     = 5'd20;

  logic [4:0]    state;
  logic [4:0]    state_next;
  logic [CW-1:0] wait_cnt;
  logic          led_done;
  logic          mem_last;

  assign mem_last = (wait_cnt == LAST);

  // Counter restarts on every state change and saturates on the last wait cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
      led_done <= 1'b0;
    end else begin
      state    <= state_next;
      led_done <= (state == P1);
      if (state_next != state)
        wait_cnt <= '0;
      else if (!mem_last)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HALTED:  if (Run) state_next = S18;
      S18:     state_next = S33;
      S33:     if (mem_last) state_next = S35;
      S35:     state_next = S32;
      S32: begin
        case (Opcode)
          4'b0001: state_next = S01;
          4'b0101: state_next = S05;
          4'b1001: state_next = S09;
          4'b0000: state_next = S00;
          4'b1100: state_next = S12;
          4'b0100: state_next = S04;
          4'b0110: state_next = S06;
          4'b0111: state_next = S07;
          4'b1101: state_next = P1;
          default: state_next = S18;
        endcase
      end
      S00:     state_next = BEN ? S22 : S18;
      S04:     state_next = S21;
      S06:     state_next = S25;
      S25:     if (mem_last) state_next = S27;
      S07:     state_next = S23;
      S23:     state_next = S16;
      S16:     if (mem_last) state_next = S18;
      P1:      if (Continue) state_next = P2;
      P2:      if (!Continue) state_next = S18;
      default: state_next = S18;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE_n   = 1'b1;
    Mem_WE_n   = 1'b1;
    case (state)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S33, S25: begin
        Mem_OE_n = 1'b0;
        LD_MDR   = mem_last;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S05) ? 2'b01 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S09: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S22: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S12: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b01;
        LD_PC   = 1'b1;
      end
      S04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin
        // JSR uses PC+off11, JSRR jumps to the base register.
        ADDR2MUX = IR_11 ? 2'b11 : 2'b00;
        ADDR1MUX = ~IR_11;
        SR1MUX   = ~IR_11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S06, S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S23: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S16: Mem_WE_n = 1'b0;
      P1:  LD_LED = ~led_done;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_slc3_control_fsm.sv
// Testbench for slc3_control_fsm: random instruction stream checked cycle by cycle
// against expected control-word sequences derived from the instruction semantics.
`timescale 1ns/1ps

module tb_slc3_control_fsm;

  localparam int MW = 2;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic       IR_5 = 1'b0;
  logic       IR_11 = 1'b0;
  logic       BEN = 1'b0;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE_n, Mem_WE_n;

  slc3_control_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n)
  );

  always #5 Clk = ~Clk;

  // Control word: one bit/field per output, strobes idle high.
  localparam logic [23:0] IDLE   = 24'h000003;
  localparam logic [23:0] B_MAR  = 24'h800000;
  localparam logic [23:0] B_MDR  = 24'h400000;
  localparam logic [23:0] B_IR   = 24'h200000;
  localparam logic [23:0] B_BEN  = 24'h100000;
  localparam logic [23:0] B_CC   = 24'h080000;
  localparam logic [23:0] B_REG  = 24'h040000;
  localparam logic [23:0] B_PC   = 24'h020000;
  localparam logic [23:0] B_LED  = 24'h010000;
  localparam logic [23:0] G_PC   = 24'h008000;
  localparam logic [23:0] G_MDR  = 24'h004000;
  localparam logic [23:0] G_ALU  = 24'h002000;
  localparam logic [23:0] G_MARM = 24'h001000;
  localparam logic [23:0] M_DR   = 24'h000200;
  localparam logic [23:0] M_SR1  = 24'h000100;
  localparam logic [23:0] M_SR2  = 24'h000080;
  localparam logic [23:0] M_A1   = 24'h000040;
  localparam logic [23:0] RD     = 24'h000001;
  localparam logic [23:0] WR     = 24'h000002;
  localparam logic [23:0] FETCH  = IDLE | G_PC | B_MAR | B_PC;
  localparam logic [23:0] MARCALC = IDLE | M_SR1 | M_A1 | 24'h000010 | G_MARM | B_MAR;

  function automatic logic [23:0] pcm(input logic [1:0] v);
    return {12'b0, v, 10'b0};
  endfunction
  function automatic logic [23:0] a2(input logic [1:0] v);
    return {18'b0, v, 4'b0};
  endfunction
  function automatic logic [23:0] alu(input logic [1:0] v);
    return {20'b0, v, 2'b0};
  endfunction

  logic [23:0] obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_OE_n, Mem_WE_n};

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_run = 1'b0;

  task automatic chk(input string tag, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [23:0] exp);
    if (rand_run) Run = 1'($urandom_range(0, 1));
    @(posedge Clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic mem_rd(input string tag);
    for (int k = 0; k < MW; k++)
      step(tag, (k == MW - 1) ? (RD | B_MDR) : RD);
  endtask

  // Entered one tick after the edge that put the DUT in S18 (already checked).
  task automatic run_instr(input logic [3:0] op, input bit i5, input bit i11,
                           input bit ben, input int hold);
    Opcode = op;
    IR_5   = i5;
    IR_11  = i11;
    BEN    = ben;
    mem_rd("fetch_rd");
    step("ir_load", IDLE | G_MDR | B_IR);
    step("decode", IDLE | B_BEN);
    case (op)
      4'd1, 4'd5: step("add_and", IDLE | M_SR1 | (i5 ? M_SR2 : 24'h0) | G_ALU | B_REG | B_CC
                                  | alu((op == 4'd5) ? 2'b01 : 2'b00));
      4'd9: step("not", IDLE | M_SR1 | G_ALU | B_REG | B_CC | alu(2'b10));
      4'd0: begin
        step("br_eval", IDLE);
        if (ben) step("br_take", IDLE | a2(2'b10) | pcm(2'b10) | B_PC);
      end
      4'd12: step("jmp", IDLE | M_SR1 | alu(2'b11) | G_ALU | pcm(2'b01) | B_PC);
      4'd4: begin
        step("jsr_r7", IDLE | G_PC | M_DR | B_REG);
        step("jsr_pc", i11 ? (IDLE | a2(2'b11) | pcm(2'b10) | B_PC)
                           : (IDLE | M_A1 | M_SR1 | pcm(2'b10) | B_PC));
      end
      4'd6: begin
        step("ldr_mar", MARCALC);
        mem_rd("ldr_rd");
        step("ldr_wb", IDLE | G_MDR | B_REG | B_CC);
      end
      4'd7: begin
        step("str_mar", MARCALC);
        step("str_mdr", IDLE | alu(2'b11) | G_ALU | B_MDR);
        for (int k = 0; k < MW; k++) step("str_wr", WR);
      end
      4'd13: begin
        step("pause_led", IDLE | B_LED);
        for (int k = 0; k < hold; k++) step("pause_hold", IDLE);
        Continue = 1'b1;
        for (int k = 0; k < 1 + hold % 3; k++) step("pause_cont", IDLE);
        Continue = 1'b0;
      end
      default: ;
    endcase
    step("fetch", FETCH);
  endtask

  initial begin
    Run = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset", IDLE);
    Reset = 1'b0;
    Run   = 1'b0;
    step("halted", IDLE);
    step("halted", IDLE);
    Run = 1'b1;
    step("start", FETCH);
    rand_run = 1'b1;

    run_instr(4'd1,  1'b1, 1'b0, 1'b0, 0);
    run_instr(4'd0,  1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd0,  1'b0, 1'b0, 1'b1, 0);
    run_instr(4'd4,  1'b0, 1'b1, 1'b0, 0);
    run_instr(4'd4,  1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd6,  1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd7,  1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd13, 1'b0, 1'b0, 1'b0, 10);
    run_instr(4'd9,  1'b1, 1'b0, 1'b0, 0);
    run_instr(4'd5,  1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd12, 1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd15, 1'b0, 1'b0, 1'b0, 0);
    run_instr(4'd8,  1'b0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)));

    // Asynchronous reset in the middle of an instruction-fetch memory read.
    step("s33_before_reset", RD);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset", IDLE);
    @(posedge Clk);
    #1;
    chk("reset_hold", IDLE);
    rand_run = 1'b0;
    Run   = 1'b0;
    Reset = 1'b0;
    step("halted_after_reset", IDLE);
    Run = 1'b1;
    step("restart", FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
